decoder_nto2n_seq: RTL
======================

Name: decoder_nto2n_seq

Overview:
Parametrised, registered N-to-2^N one-hot decoder. Generalises our combinational 3:8 / 2:4 decoders to any input width. Adds a valid/ready input handshake and three output modes: latched, single-cycle pulse, and auto-sweep. Intended for chip-select / row-select generation where the one-hot must be timed, held or scanned rather than follow the input combinationally.

Parameters:
IN_W, 3, code width; output width OUT_W = 2**IN_W is a derived localparam, not overridable; legal IN_W 1..6
SWEEP_DWELL, 1, cycles each output stays hot in sweep mode; legal 1..255
ACTIVE_LOW, 0, 1 = every bit of out inverted (idle all-ones, hot bit 0); out_valid is unaffected

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; low forces idle
mode  input  2  00 latch, 01 pulse, 10 sweep, 11 reserved (treated as latch); sampled only on accept
in_valid  input  1  in_code/mode valid
in_ready  output  1  block can accept; accept = in_valid & in_ready
in_code  input  IN_W  code to decode / sweep start index
out  output  OUT_W  registered one-hot (polarity per ACTIVE_LOW)
out_valid  output  1  high when exactly one bit of out is hot
busy  output  1  high while in SWEEP state

Behaviour:
- Reset (rst_n low, async): state IDLE, out = all 0 (all 1 if ACTIVE_LOW), out_valid 0, busy 0, dwell counter 0, sweep index 0. in_ready = 0 while in reset.
- in_ready is combinational: en & (state != SWEEP). Not dependent on in_valid.
- Latency: code accepted at edge k -> out hot bit in_code visible immediately after edge k (1 cycle).
- States and transitions (all at rising edge, en high):
  IDLE: out idle. On accept -> HOLD (mode 00/11), PULSE (01) or SWEEP (10); out = onehot(in_code).
  HOLD: out held. New accept replaces out with new onehot and moves to the state for the new mode. No accept -> stay.
  PULSE: out hot for exactly one cycle. Accept in the same cycle -> new onehot and its mode's state (back-to-back pulses give consecutive single-cycle pulses, no gap). Otherwise -> IDLE, out idle.
  SWEEP: index starts at in_code, out = onehot(index). Each index held SWEEP_DWELL cycles (counter counts 0..SWEEP_DWELL-1). On expiry: index < OUT_W-1 -> index+1, counter 0. Index == OUT_W-1 -> IDLE, out idle. No wrap-around. in_valid ignored (in_ready 0).
- Sweep starting at OUT_W-1: single index, SWEEP_DWELL cycles, then IDLE.
- en deasserted (any state, incl. mid-sweep): next edge -> IDLE, out idle, counters cleared. Pending in_valid is not accepted (in_ready 0). On en re-assert, no sweep resumes.
- Reset asserted mid-operation: immediate return to reset values, no partial completion.
- out_valid = 1 in HOLD, PULSE and SWEEP; 0 in IDLE. It is registered and aligned with out.
- At most one bit of out is ever hot; an all-idle out occurs only with out_valid 0.
- Index and counter arithmetic are unsigned. Counter width = clog2(SWEEP_DWELL+1). Index width = IN_W, with compare-before-increment so no overflow occurs.

Test Plan:
- Reset/latch: IN_W=3; release rst_n, en=1, accept code 5 mode 00 -> next cycle out=8'b0010_0000, out_valid=1, held 10 cycles; accept code 2 -> out=8'b0000_0100.
- Pulse back-to-back: mode 01, codes 0,1,7 on three consecutive cycles -> out 01,02,80 on three consecutive cycles, then 00 with out_valid=0.
- Sweep: SWEEP_DWELL=2, accept code 5 mode 10 -> out 20,20,40,40,80,80 then 00. busy=1 and in_ready=0 for exactly 6 cycles; an in_valid pulse during the sweep is ignored.
- Abort: sweep from 0 with SWEEP_DWELL=1; drop en at 3rd cycle -> out 00 next edge, state IDLE. Re-raise en -> out stays 00 until a new accept.
- Async reset mid-HOLD: assert rst_n low between edges -> out goes 00 without waiting for a clock edge; out_valid=0.
- ACTIVE_LOW=1, IN_W=4: after reset out=16'hFFFF. Accept code 9 mode 00 -> out=16'hFDFF, out_valid=1. Mode 11 behaves identically to mode 00.

Source files
------------

// File: rtl/decoder_nto2n_seq_if.sv
// Handshake and output bundle for the sequenced N-to-2^N decoder.
// master drives codes in, slave returns the registered one-hot.
interface decoder_nto2n_seq_if #(
  parameter int IN_W = 3
);
  localparam int OUT_W = 2 ** IN_W;

  logic             en;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             busy;

  modport master (
    output en,
    output mode,
    output in_valid,
    output in_code,
    input  in_ready,
    input  out,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  en,
    input  mode,
    input  in_valid,
    input  in_code,
    output in_ready,
    output out,
    output out_valid,
    output busy
  );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with latch, pulse
// and auto-sweep modes behind a valid/ready handshake.
module decoder_nto2n_seq #(
  parameter int IN_W        = 3,
  parameter int SWEEP_DWELL = 1,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  decoder_nto2n_seq_if.slave  bus
);

  localparam int OUT_W = 2 ** IN_W;
  localparam int CNT_W = $clog2(SWEEP_DWELL + 1);

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(SWEEP_DWELL - 1);
  localparam logic [IN_W-1:0]  LAST_IDX =
    IN_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PULSE,
    SWEEP
  } state_e;

  state_e           state_q, state_d;
  state_e           load_st;
  logic [OUT_W-1:0] hot_q, hot_d;
  logic             vld_q, vld_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             do_load;
  logic             do_clr;

  function automatic logic [OUT_W-1:0] onehot(
    input logic [IN_W-1:0] c
  );
    return OUT_W'(1) << c;
  endfunction

  assign bus.in_ready  = rst_n & bus.en & (state_q != SWEEP);
  assign bus.out       = ACTIVE_LOW ? ~hot_q : hot_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = (state_q == SWEEP);
  assign accept        = bus.in_valid & bus.in_ready;

  // Reserved mode 11 falls through to latch.
  always_comb begin
    load_st = HOLD;
    unique case (1'b1)
      (bus.mode == 2'b01): load_st = PULSE;
      (bus.mode == 2'b10): load_st = SWEEP;
      default:             load_st = HOLD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hot_d   = hot_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    do_load = 1'b0;
    do_clr  = 1'b0;

    if (!bus.en) begin
      do_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          do_load = accept;
        end
        PULSE: begin
          do_load = accept;
          do_clr  = !accept;
        end
        SWEEP: begin
          // Compare before increment: index never wraps.
          if (cnt_q == LAST_CNT) begin
            if (idx_q == LAST_IDX) begin
              do_clr = 1'b1;
            end else begin
              idx_d = idx_q + IN_W'(1);
              cnt_d = '0;
              hot_d = onehot(idx_q + IN_W'(1));
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          do_clr = 1'b1;
        end
      endcase
    end

    if (do_load) begin
      state_d = load_st;
      hot_d   = onehot(bus.in_code);
      vld_d   = 1'b1;
      idx_d   = bus.in_code;
      cnt_d   = '0;
    end else if (do_clr) begin
      state_d = IDLE;
      hot_d   = '0;
      vld_d   = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hot_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hot_q   <= hot_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
